// File: rtl/wb_vmon_pkg.sv
// Shared width helpers for the vmon mailbox write snooper.
package wb_vmon_pkg;

    localparam int unsigned BYTE_BITS = 8;

    function automatic int unsigned lane_count(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

    function automatic int unsigned byte_lsb(input int unsigned data_width);
        return $clog2(data_width / BYTE_BITS);
    endfunction

    function automatic int unsigned offset_width(input int unsigned window_words);
        return $clog2(window_words);
    endfunction

endpackage

// File: rtl/wb_vmon_fifo.sv
// Generic order-preserving FIFO; head is read combinationally from storage.
module wb_vmon_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty at equal indices.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_vmon_snoop.sv
// Passive Wishbone snooper: queues completed writes into the vmon mailbox
// window as events and tracks events lost to a full queue.
module wb_vmon_snoop
    import wb_vmon_pkg::*;
#(
    parameter int unsigned                 WB_ADDR_WIDTH = 32,
    parameter int unsigned                 WB_DATA_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0]    ADDRESS       = 'h6000_1000,
    parameter int unsigned                 WINDOW_WORDS  = 4,
    parameter int unsigned                 FIFO_DEPTH    = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [WB_ADDR_WIDTH-1:0]             ADR,
    input  logic [WB_DATA_WIDTH-1:0]             DAT_W,
    input  logic                                 CYC,
    input  logic                                 STB,
    input  logic                                 WE,
    input  logic [WB_DATA_WIDTH/8-1:0]           SEL,
    input  logic                                 ACK,
    input  logic                                 ERR,
    output logic                                 ev_valid,
    input  logic                                 ev_ready,
    output logic [$clog2(WINDOW_WORDS)-1:0]      ev_offset,
    output logic [WB_DATA_WIDTH-1:0]             ev_data,
    output logic [WB_DATA_WIDTH/8-1:0]           ev_sel,
    output logic                                 overflow,
    input  logic                                 ovf_clr,
    output logic [15:0]                          drop_count
);

    localparam int unsigned SEL_W   = lane_count(WB_DATA_WIDTH);
    localparam int unsigned OFF_W   = offset_width(WINDOW_WORDS);
    localparam int unsigned OFF_LSB = byte_lsb(WB_DATA_WIDTH);
    localparam int unsigned WIN_LSB = OFF_LSB + OFF_W;

    typedef struct packed {
        logic [OFF_W-1:0]         offset;
        logic [WB_DATA_WIDTH-1:0] data;
        logic [SEL_W-1:0]         sel;
    } vmon_event_t;

    localparam int unsigned EV_W = $bits(vmon_event_t);

    vmon_event_t ev_in;
    vmon_event_t ev_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        in_window;
    logic        hit;
    logic        pop;
    logic        drop;
    logic        unused_low_adr;

    // Window is size-aligned, so a tag compare above the window bits suffices.
    assign in_window      = (ADR[WB_ADDR_WIDTH-1:WIN_LSB] == ADDRESS[WB_ADDR_WIDTH-1:WIN_LSB]);
    assign hit            = CYC & STB & WE & ACK & ~ERR & in_window;
    assign unused_low_adr = ^ADR[WIN_LSB-1:0];

    assign ev_valid = ~fifo_empty;
    assign pop      = ev_valid & ev_ready;
    assign drop     = hit & fifo_full & ~pop;

    always_comb begin
        ev_in        = '0;
        ev_in.offset = ADR[WIN_LSB-1:OFF_LSB];
        ev_in.data   = DAT_W;
        ev_in.sel    = SEL;
    end

    wb_vmon_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (hit & ~drop),
        .din   (ev_in),
        .pop   (pop),
        .dout  (ev_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev_offset = ev_head.offset;
    assign ev_data   = ev_head.data;
    assign ev_sel    = ev_head.sel;

    // A drop coincident with a clear restarts the count at one.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_wb_vmon_snoop.sv
// Directed bench for wb_vmon_snoop with hand-computed expectations.
module tb_wb_vmon_snoop;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] ADR;
    logic [31:0] DAT_W;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [3:0]  SEL;
    logic        ACK;
    logic        ERR;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_offset;
    logic [31:0] ev_data;
    logic [3:0]  ev_sel;
    logic        overflow;
    logic        ovf_clr;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_errors = 0;

    wb_vmon_snoop #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .ADDRESS       (32'h6000_1000),
        .WINDOW_WORDS  (4),
        .FIFO_DEPTH    (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ADR        (ADR),
        .DAT_W      (DAT_W),
        .CYC        (CYC),
        .STB        (STB),
        .WE         (WE),
        .SEL        (SEL),
        .ACK        (ACK),
        .ERR        (ERR),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_offset  (ev_offset),
        .ev_data    (ev_data),
        .ev_sel     (ev_sel),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .drop_count (drop_count)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        CYC = 1'b0; STB = 1'b0; WE = 1'b0; ACK = 1'b0; ERR = 1'b0;
        ADR = '0; DAT_W = '0; SEL = '0;
    endtask

    // Drive one bus cycle from a negedge; the following posedge samples it.
    task automatic bus_drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic we, input logic ack, input logic err);
        CYC = 1'b1; STB = 1'b1; WE = we; ACK = ack; ERR = err;
        ADR = a; DAT_W = d; SEL = s;
    endtask

    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic we, input logic ack, input logic err);
        bus_drive(a, d, s, we, ack, err);
        @(negedge clk_i);
        bus_idle();
    endtask

    initial begin
        rst_i = 1'b0;
        ev_ready = 1'b0;
        ovf_clr = 1'b0;
        bus_idle();
        repeat (2) @(negedge clk_i);

        check("rst_valid", ev_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drops", drop_count, 0);
        check("rst_offset", ev_offset, 0);
        check("rst_data", ev_data, 0);
        check("rst_sel", ev_sel, 0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Single write into word 2
        bus_xfer(32'h6000_1008, 32'hDEAD_BEEF, 4'hF, 1, 1, 0);
        check("single_valid", ev_valid, 1);
        check("single_offset", ev_offset, 2);
        check("single_data", ev_data, 32'hDEAD_BEEF);
        check("single_sel", ev_sel, 4'hF);
        ev_ready = 1'b1;
        @(negedge clk_i);
        ev_ready = 1'b0;
        check("single_popped", ev_valid, 0);

        // Filtering
        bus_xfer(32'h6000_1000, 32'h1111, 4'hF, 0, 1, 0);
        check("flt_read", ev_valid, 0);
        bus_xfer(32'h6000_1010, 32'h2222, 4'hF, 1, 1, 0);
        check("flt_above", ev_valid, 0);
        bus_xfer(32'h6000_0FFC, 32'h3333, 4'hF, 1, 1, 0);
        check("flt_below", ev_valid, 0);
        bus_xfer(32'h6000_1000, 32'h4444, 4'hF, 1, 1, 1);
        check("flt_ackerr", ev_valid, 0);
        bus_xfer(32'h6000_1004, 32'h5555, 4'hF, 1, 0, 0);
        check("flt_noack", ev_valid, 0);

        // Back-to-back writes, popped in order; low byte bits ignored
        for (int i = 0; i < 4; i++) begin
            bus_drive(32'h6000_1000 + 32'(i * 4) + 32'(i % 4 == 3 ? 2 : 0), 32'(i + 1),
                      4'(1 << i), 1, 1, 0);
            @(negedge clk_i);
        end
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid", ev_valid, 1);
            check("b2b_offset", ev_offset, 64'(i));
            check("b2b_data", ev_data, 64'(i + 1));
            check("b2b_sel", ev_sel, 64'(1 << i));
            ev_ready = 1'b1;
            @(negedge clk_i);
        end
        ev_ready = 1'b0;
        check("b2b_empty", ev_valid, 0);

        // Overflow: 10 writes into an 8-deep queue
        for (int i = 0; i < 10; i++) begin
            bus_drive(32'h6000_1000 + 32'((i % 4) * 4), 32'h100 + 32'(i), 4'hF, 1, 1, 0);
            @(negedge clk_i);
        end
        bus_idle();
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_count, 2);
        check("ovf_head", ev_data, 32'h100);
        ovf_clr = 1'b1;
        @(negedge clk_i);
        ovf_clr = 1'b0;
        check("clr_flag", overflow, 0);
        check("clr_drops", drop_count, 0);
        check("clr_head", ev_data, 32'h100);
        check("clr_valid", ev_valid, 1);

        // Full with simultaneous pop and hit: accepted, no drop
        ev_ready = 1'b1;
        bus_xfer(32'h6000_1004, 32'hAAA, 4'h3, 1, 1, 0);
        ev_ready = 1'b0;
        check("fullpop_flag", overflow, 0);
        check("fullpop_drops", drop_count, 0);
        check("fullpop_head", ev_data, 32'h101);
        // Still full: a further hit drops, together with a clear
        ovf_clr = 1'b1;
        bus_xfer(32'h6000_1000, 32'hBBB, 4'hF, 1, 1, 0);
        ovf_clr = 1'b0;
        check("dropclr_flag", overflow, 1);
        check("dropclr_drops", drop_count, 1);
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", ev_valid, 1);
            check("drain_data", ev_data, (i < 7) ? 64'(32'h101 + i) : 64'hAAA);
            ev_ready = 1'b1;
            @(negedge clk_i);
        end
        ev_ready = 1'b0;
        check("drain_empty", ev_valid, 0);

        // Async reset mid-cycle with events queued
        for (int i = 0; i < 3; i++) begin
            bus_xfer(32'h6000_100C, 32'h77 + 32'(i), 4'hF, 1, 1, 0);
        end
        check("pre_rst_valid", ev_valid, 1);
        #2 rst_i = 1'b0;
        #1;
        check("arst_valid", ev_valid, 0);
        check("arst_ovf", overflow, 0);
        check("arst_drops", drop_count, 0);
        check("arst_data", ev_data, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        bus_xfer(32'h6000_100C, 32'h55, 4'h8, 1, 1, 0);
        check("post_rst_offset", ev_offset, 3);
        check("post_rst_data", ev_data, 32'h55);
        check("post_rst_sel", ev_sel, 4'h8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
